noc_arbiter: RTL and testbench

- Output-port arbiter of the NoC router. Picks one of five input-port buffers (Local, North, East, South, West) that request the output, and holds the grant for one packet.
- Scheduling is round-robin, with the last-served port at lowest priority. Base rotation order is L→N→E→S→W→L.
- Reports the current grant state as a 6-bit one-hot code that drives the crossbar select and buffer read enables.

---
 rtl/noc_pkg.sv | 45 ++++
 rtl/noc_rr_picker.sv | 29 ++
 rtl/noc_arbiter.sv | 88 ++++++++
 tb/tb_noc_arbiter.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared codes for the NoC output-port arbiter: flit types, one-hot grant
// states and input-port indices.
package noc_pkg;
  localparam int NUM_PORTS = 5;

  localparam logic [2:0] HEADER  = 3'b001;
  localparam logic [2:0] PAYLOAD = 3'b010;
  localparam logic [2:0] TAIL    = 3'b011;

  localparam logic [2:0] L = 3'd0;
  localparam logic [2:0] N = 3'd1;
  localparam logic [2:0] E = 3'd2;
  localparam logic [2:0] S = 3'd3;
  localparam logic [2:0] W = 3'd4;

  typedef enum logic [5:0] {
    IDLE  = 6'b000001,
    GNT_L = 6'b000010,
    GNT_N = 6'b000100,
    GNT_E = 6'b001000,
    GNT_S = 6'b010000,
    GNT_W = 6'b100000
  } state_e;

  function automatic state_e gnt_of(input logic [2:0] p);
    case (p)
      L:       return GNT_L;
      N:       return GNT_N;
      E:       return GNT_E;
      S:       return GNT_S;
      W:       return GNT_W;
      default: return IDLE;
    endcase
  endfunction

  function automatic logic [2:0] port_of(input state_e s);
    case (s)
      GNT_N:   return N;
      GNT_E:   return E;
      GNT_S:   return S;
      GNT_W:   return W;
      default: return L;
    endcase
  endfunction
endpackage

// File: rtl/noc_rr_picker.sv
// Combinational round-robin picker: scans requests starting just after
// `last`, so the last-served port is considered last.
module rr_picker
  import noc_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic [2:0]           last,
  output logic [2:0]           win,
  output logic                 vld
);
  logic [3:0] sum;
  logic [2:0] idx;

  // Walk the scan order backwards so the earliest requester overwrites last.
  always_comb begin
    win = '0;
    vld = 1'b0;
    sum = '0;
    idx = '0;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      sum = {1'b0, last} + 4'(i);
      idx = (sum >= 4'(NUM_PORTS)) ? 3'(sum - 4'(NUM_PORTS)) : sum[2:0];
      if (req[idx]) begin
        win = idx;
        vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/noc_arbiter.sv
// NoC router output-port arbiter: round-robin over five input buffers,
// holding each grant until TAIL or a length-based timeout.
module noc_arbiter
  import noc_pkg::*;
#(
  parameter int FLIT_ID_W = 3,
  parameter int LEN_W     = 12,
  parameter int STATE_W   = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FLIT_ID_W-1:0] Lflit_id,
  input  logic [FLIT_ID_W-1:0] Nflit_id,
  input  logic [FLIT_ID_W-1:0] Eflit_id,
  input  logic [FLIT_ID_W-1:0] Wflit_id,
  input  logic [FLIT_ID_W-1:0] Sflit_id,
  input  logic [LEN_W-1:0]     Llength,
  input  logic [LEN_W-1:0]     Nlength,
  input  logic [LEN_W-1:0]     Elength,
  input  logic [LEN_W-1:0]     Wlength,
  input  logic [LEN_W-1:0]     Slength,
  input  logic                 Lreq,
  input  logic                 Nreq,
  input  logic                 Ereq,
  input  logic                 Wreq,
  input  logic                 Sreq,
  output logic [STATE_W-1:0]   nextstate
);
  state_e               state, state_n;
  logic [2:0]           last_served, last_n, pick_last, cur, win;
  logic [LEN_W-1:0]     cnt, cnt_n, len_eff;
  logic [NUM_PORTS-1:0] req_v;
  logic [FLIT_ID_W-1:0] flit_v [NUM_PORTS];
  logic [LEN_W-1:0]     len_v  [NUM_PORTS];
  logic                 vld, release_x;

  assign req_v     = {Wreq, Sreq, Ereq, Nreq, Lreq};
  assign flit_v    = '{Lflit_id, Nflit_id, Eflit_id, Sflit_id, Wflit_id};
  assign len_v     = '{Llength, Nlength, Elength, Slength, Wlength};
  assign nextstate = STATE_W'(state);

  assign cur     = port_of(state);
  assign len_eff = (len_v[cur] == '0) ? LEN_W'(1) : len_v[cur];
  // Extra bit keeps cnt+1 from wrapping when cnt is saturated.
  assign release_x = (flit_v[cur] == FLIT_ID_W'(TAIL)) ||
                     (({1'b0, cnt} + 1'b1) >= {1'b0, len_eff});

  // On release the current port becomes last-served in the same cycle,
  // so back-to-back grants already rotate past it.
  assign pick_last = (state == IDLE) ? last_served : cur;

  rr_picker u_pick (
    .req  (req_v),
    .last (pick_last),
    .win  (win),
    .vld  (vld)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      last_served <= W;
      cnt         <= '0;
    end else begin
      state       <= state_n;
      last_served <= last_n;
      cnt         <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    last_n  = last_served;
    cnt_n   = cnt;
    if (state == IDLE) begin
      if (vld) begin
        state_n = gnt_of(win);
        cnt_n   = '0;
      end
    end else if (release_x) begin
      last_n  = cur;
      cnt_n   = '0;
      state_n = vld ? gnt_of(win) : IDLE;
    end else begin
      cnt_n = (&cnt) ? cnt : cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_noc_arbiter.sv
// Directed bench for noc_arbiter: reset, single pulses per port, rotation,
// last-served priority, early TAIL, zero length and async reset mid-grant.
module tb_noc_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  req;
  logic [2:0]  flit [5];
  logic [11:0] len  [5];
  logic [5:0]  nextstate;
  logic [5:0]  gnt_code [5];
  int          checks = 0;
  int          fails  = 0;

  localparam logic [5:0] ST_IDLE = 6'b000001;
  localparam logic [2:0] F_HDR = 3'b001, F_PAY = 3'b010, F_TAIL = 3'b011;

  noc_arbiter dut (
    .clk(clk), .rst(rst),
    .Lflit_id(flit[0]), .Nflit_id(flit[1]), .Eflit_id(flit[2]),
    .Wflit_id(flit[4]), .Sflit_id(flit[3]),
    .Llength(len[0]), .Nlength(len[1]), .Elength(len[2]),
    .Wlength(len[4]), .Slength(len[3]),
    .Lreq(req[0]), .Nreq(req[1]), .Ereq(req[2]), .Wreq(req[4]), .Sreq(req[3]),
    .nextstate(nextstate)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [5:0] exp);
    checks++;
    assert (nextstate === exp) else begin
      fails++;
      $error("FAIL %s: got %b expected %b", tag, nextstate, exp);
    end
  endtask

  initial begin
    gnt_code = '{6'b000010, 6'b000100, 6'b001000, 6'b010000, 6'b100000};
    req = '0;
    for (int p = 0; p < 5; p++) begin
      flit[p] = F_PAY;
      len[p]  = 12'd5;
    end

    // Asynchronous reset with random inputs
    #3;
    req = 5'($urandom);
    for (int p = 0; p < 5; p++) flit[p] = 3'($urandom);
    rst = 1'b0;
    #1 chk("reset_async", ST_IDLE);
    tick(); chk("reset_hold1", ST_IDLE);
    tick(); chk("reset_hold2", ST_IDLE);
    req = '0;
    for (int p = 0; p < 5; p++) flit[p] = F_PAY;
    #2 rst = 1'b1;
    tick(); chk("idle_noreq1", ST_IDLE);
    tick(); chk("idle_noreq2", ST_IDLE);

    // Single-cycle pulse per port; neighbour's TAIL must be ignored
    for (int p = 0; p < 5; p++) begin
      req     = 5'(1 << p);
      flit[p] = F_HDR;
      tick();
      req = '0;
      flit[(p + 1) % 5] = F_TAIL;
      for (int k = 0; k < 5; k++) begin
        flit[p] = (k == 4) ? F_TAIL : ((k == 0) ? F_HDR : F_PAY);
        chk($sformatf("pulse_p%0d_c%0d", p, k), gnt_code[p]);
        tick();
      end
      chk($sformatf("pulse_p%0d_end", p), ST_IDLE);
      flit[p] = F_PAY;
      flit[(p + 1) % 5] = F_PAY;
    end

    // All requesting, no TAIL: 5-cycle timeout grants rotate back-to-back
    req = 5'b11111;
    tick();
    for (int g = 0; g < 10; g++) begin
      for (int c = 0; c < 5; c++) begin
        chk($sformatf("rot_g%0d_c%0d", g, c), gnt_code[g % 5]);
        tick();
      end
    end
    chk("rot_wrap_L", gnt_code[0]);
    req = '0;
    repeat (5) tick();
    chk("rot_drain", ST_IDLE);

    // Last-served gets lowest priority
    req = 5'b10000;
    tick(); chk("serve_w", gnt_code[4]);
    req = '0;
    repeat (5) tick();
    chk("serve_w_end", ST_IDLE);
    req = 5'b10010;
    tick(); chk("ls_w_n_pick_n", gnt_code[1]);
    req = 5'b10000;
    repeat (5) tick();
    chk("ls_then_w", gnt_code[4]);
    req = '0;
    repeat (5) tick();
    chk("ls_end", ST_IDLE);

    // Early TAIL on second grant cycle; req drop does not release
    req = 5'b00100;
    tick(); chk("etail_c1", gnt_code[2]);
    req = '0;
    tick(); chk("etail_c2_reqdrop", gnt_code[2]);
    flit[2] = F_TAIL;
    tick(); chk("etail_release", ST_IDLE);
    flit[2] = F_PAY;

    // Length 0 behaves as length 1
    len[3] = 12'd0;
    req = 5'b01000;
    tick(); chk("len0_grant", gnt_code[3]);
    req = '0;
    tick(); chk("len0_release", ST_IDLE);
    len[3] = 12'd5;

    // Asynchronous reset mid-grant, then L wins over S
    req = 5'b01000;
    tick(); req = '0;
    tick(); chk("mid_gnt_s", gnt_code[3]);
    #2 rst = 1'b0;
    #1 chk("mid_rst_async", ST_IDLE);
    #2 rst = 1'b1;
    req = 5'b01001;
    tick(); chk("post_rst_l_first", gnt_code[0]);
    req = '0;

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
